load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle data-memory access stage driven by the 3-bit mem code from the ALU control stage.
//  Takes the ALU-computed effective address and store data, then issues one word-aligned request
//  with byte enables to data memory. Waits for ack, aligns and extends load data, and signals completion.
//  Sits between the ALU output and register-file writeback; the core stalls while busy=1.
// PARAMETERS
//  TIMEOUT_CYCLES  15  max cycles in ACCESS without dmem_ack before aborting (1..255)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  start        in   1   begin access; sampled only in IDLE
//  mem_op       in   3   001 byte, 010 half, 011 word, 101 byte-unsigned; 000/100/110/111 illegal
//  mem_write    in   1   1 = store, 0 = load
//  addr         in   32  effective byte address
//  wdata        in   32  store data (low bits used for byte/half)
//  busy         out  1   high from the cycle after an accepted start until done
//  done         out  1   one-cycle completion pulse
//  rdata        out  32  aligned, extended load result; held until next accepted start
//  err          out  2   00 ok, 01 misaligned, 10 illegal op, 11 timeout; valid with done, held
//  dmem_req     out  1   request; held high until ack or timeout
//  dmem_we      out  1   write strobe, qualified by dmem_req
//  dmem_be      out  4   byte enables, bit i = byte lane i
//  dmem_addr    out  32  {addr[31:2],2'b00}
//  dmem_wdata   out  32  lane-replicated store data
//  dmem_ack     in   1   memory completed; dmem_rdata valid in the same cycle
//  dmem_rdata   in   32  read word
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, dmem_req, dmem_we = 0; dmem_be = 0; rdata, err, dmem_addr, dmem_wdata = 0.
//  FSM IDLE -> ACCESS -> DONE -> IDLE. All inputs are registered when start is accepted.
//  IDLE: start=1 is accepted. Illegal op, or store with op 101, goes to DONE with err=10.
//   Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) goes to DONE with err=01.
//   Any other access goes to ACCESS. No memory request is issued on an error.
//  ACCESS: dmem_req=1. When dmem_ack=1, capture data and go to DONE with err=00.
//   The timeout counter runs from 0 and increments each cycle without ack. When it reaches
//   TIMEOUT_CYCLES, drop req and go to DONE with err=11. Ack on the same edge as timeout counts as success.
//  DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
//  Latency: start at cycle 0, req at cycle 1, ack at cycle 1, done at cycle 2 (minimum).
//   An error detected at start gives done at cycle 1.
//  Store lanes: byte sets be=0001<<addr[1:0] and wdata={4{wdata[7:0]}}.
//   Half sets be=0011 (addr[1]=0) or 1100 (addr[1]=1) and wdata={2{wdata[15:0]}}. Word sets be=1111.
//   Load be is the same as for a store of that size.
//  Load extract: lane = dmem_rdata >> (8*addr[1:0]). Byte and half are sign-extended; 101 is zero-extended.
//   A store leaves rdata at 0.
//  start while busy or in DONE is ignored. dmem_ack outside ACCESS is ignored.
//  rst in any state returns to IDLE on that edge, drops dmem_req and emits no done.
// STRUCTURE
//  Shared package: mem-op codes (MEM_LB=3'b001, MEM_LH=3'b010, MEM_LW=3'b011, MEM_LBU=3'b101),
//   error codes, and the FSM state enum.
//  Sub-module lsu_align (combinational): byte-enable and store replication, plus load extract and extend.
//  The top level holds the FSM, timeout counter and capture registers.
// TESTING
//  1 lw, addr=0x100, ack at 3rd ACCESS cycle, rdata_in=0xDEADBEEF -> be=1111, rdata=0xDEADBEEF, err=00, done once.
//  2 lb, addr=0x103, rdata_in=0x80FF0000 -> be=1000, rdata=0xFFFFFF80; same with lbu -> 0x00000080.
//  3 sh, addr=0x202, wdata=0x1234ABCD -> dmem_we=1, be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200.
//  4 lw, addr=0x101 -> no dmem_req, done at cycle 1, err=01; mem_op=000 -> err=10.
//  5 lw, ack never asserted, TIMEOUT_CYCLES=4 -> req high 4 cycles then drops, done with err=11.
//  6 rst pulsed mid-ACCESS, then ack -> req=0 after reset edge, no done, second start served normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_pkg
// Desc     : Shared mem-op codes, error codes, FSM states and the start-time
//            legality/alignment check for the load/store unit.
// Revision : 1.0  initial release
// ============================================================================
package load_store_unit_pkg;

  localparam logic [2:0] MEM_LB  = 3'b001;
  localparam logic [2:0] MEM_LH  = 3'b010;
  localparam logic [2:0] MEM_LW  = 3'b011;
  localparam logic [2:0] MEM_LBU = 3'b101;

  localparam logic [1:0] c_err_ok       = 2'b00;
  localparam logic [1:0] c_err_misalign = 2'b01;
  localparam logic [1:0] c_err_illegal  = 2'b10;
  localparam logic [1:0] c_err_timeout  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_t;

  // Classify an access at start time. Illegal op wins over misalignment;
  // an unsigned-byte store has no meaning and is treated as illegal.
  function automatic logic [1:0] check_access(input logic [2:0] op,
                                              input logic       write,
                                              input logic [1:0] addr_lo);
    logic legal;
    legal = (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) || (op == MEM_LBU);
    if (!legal || (write && (op == MEM_LBU))) return c_err_illegal;
    if ((op == MEM_LH) && addr_lo[0])          return c_err_misalign;
    if ((op == MEM_LW) && (addr_lo != 2'b00))  return c_err_misalign;
    return c_err_ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Desc     : Combinational lane logic: byte enables and store replication for
//            the outgoing request, lane extract and sign/zero extend for loads.
// Revision : 1.0  initial release
// ============================================================================
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_mem_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_lane;

  // Size-dependent lane selection; unknown ops produce an all-zero request.
  always_comb begin
    w_lane  = i_rdata >> {i_addr_lo, 3'b000};
    o_be    = 4'b0000;
    o_wdata = '0;
    o_rdata = '0;
    case (i_mem_op)
      MEM_LB, MEM_LBU: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = (i_mem_op == MEM_LB) ? {{24{w_lane[7]}}, w_lane[7:0]}
                                       : {24'h000000, w_lane[7:0]};
      end
      MEM_LH: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_lane[15]}}, w_lane[15:0]};
      end
      MEM_LW: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Desc     : Multi-cycle data-memory access stage. Captures the request on
//            start, issues one word-aligned access, waits for ack or timeout,
//            and returns aligned load data with a one-cycle done pulse.
// Revision : 1.0  initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  mem_op,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  // Counter value on the last ACCESS cycle before giving up.
  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  r_state;
  lsu_state_t  w_state_next;
  logic [2:0]  r_op;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_tmo_cnt;
  logic [31:0] r_rdata;
  logic [1:0]  r_err;
  logic [1:0]  w_start_err;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_load_data;

  assign w_start_err = check_access(mem_op, mem_write, addr[1:0]);
  assign w_timeout   = (r_tmo_cnt == c_tmo_last);

  lsu_align u_align (
    .i_mem_op  (r_op),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rdata   (dmem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_load_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; errors found at start skip the memory access entirely.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = (w_start_err != c_err_ok) ? ST_DONE : ST_ACCESS;
      ST_ACCESS: if (dmem_ack || w_timeout) w_state_next = ST_DONE;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Request capture, timeout counting and result registers. Ack takes
  // priority over timeout when both land on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= '0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tmo_cnt <= '0;
      r_rdata   <= '0;
      r_err     <= c_err_ok;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op      <= mem_op;
            r_write   <= mem_write;
            r_addr    <= addr;
            r_wdata   <= wdata;
            r_tmo_cnt <= '0;
            r_rdata   <= '0;
            r_err     <= w_start_err;
          end
        end
        ST_ACCESS: begin
          if (dmem_ack) begin
            if (!r_write) r_rdata <= w_load_data;
            r_err <= c_err_ok;
          end else if (w_timeout) begin
            r_err <= c_err_timeout;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign dmem_req   = (r_state == ST_ACCESS);
  assign dmem_we    = (r_state == ST_ACCESS) && r_write;
  assign dmem_be    = (r_state == ST_ACCESS) ? w_be : 4'b0000;
  assign dmem_addr  = {r_addr[31:2], 2'b00};
  assign dmem_wdata = w_wdata_rep;
  assign rdata      = r_rdata;
  assign err        = r_err;

endmodule
`default_nettype wire
